// File: rtl/line_solver.sv
// line_solver: nonogram-style line propagation for a ROWS x COLS grid.
//
// The block receives every candidate fill of one line (a row or a column) as a
// stream of option beats. Options that disagree with cells already known are
// dropped. The surviving options are reduced to an AND and an OR per cell. A
// cell is fixed to 1 when every survivor has it set, and to 0 when no survivor
// has it set. The grid is updated once, after the last beat of the line.
//
// Optional feature: define LINE_SOLVER_STATS_EN to add the lines_done and
// options_pruned statistics counters.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous reset, active low
//   opt_valid      option beat valid
//   opt_ready      block accepts a beat this cycle (IDLE / ACCUM)
//   opt_last       final option of the current line
//   row            1 = row line, 0 = column line (sampled on first beat)
//   line_ind       line index (sampled on first beat)
//   option         candidate fill, bit i = cell i along the line
//   assigned       cell values, assigned[r][c]
//   known          cell-determined flags, known[r][c]
//   done_valid     one-cycle pulse, line result valid
//   surviving      number of non-contradicting options for the line
//   changed        at least one cell became known on this line
//   contradiction  no option survived
//   solved         every cell is known
//   lines_done     (stats) completed lines, wrapping
//   options_pruned (stats) rejected option beats, wrapping
module line_solver #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int CNT_W = 8,
    localparam int L_MAX = (ROWS > COLS) ? ROWS : COLS,
    localparam int IDX_W = (L_MAX > 1) ? $clog2(L_MAX) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       opt_valid,
    output logic                       opt_ready,
    input  logic                       opt_last,
    input  logic                       row,
    input  logic [IDX_W-1:0]           line_ind,
    input  logic [L_MAX-1:0]           option,
    output logic [ROWS-1:0][COLS-1:0]  assigned,
    output logic [ROWS-1:0][COLS-1:0]  known,
    output logic                       done_valid,
    output logic [CNT_W-1:0]           surviving,
    output logic                       changed,
    output logic                       contradiction,
`ifdef LINE_SOLVER_STATS_EN
    output logic [31:0]                lines_done,
    output logic [31:0]                options_pruned,
`endif
    output logic                       solved
);

    typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, DONE} state_t;

    state_t                     state, state_nx;
    logic                       row_q;
    logic [IDX_W-1:0]           ind_q;
    logic [CNT_W-1:0]           cnt;
    logic [L_MAX-1:0]           and_acc, or_acc;

    logic                       accept, sel_row, line_ok, consistent, any_new;
    logic                       a_bit, o_bit;
    int                         ind, len;
    logic [L_MAX-1:0]           line_asg, line_kn, mask;
    logic [ROWS-1:0][COLS-1:0]  known_nx, assigned_nx;

    assign opt_ready  = (state == IDLE) || (state == ACCUM);
    assign done_valid = (state == DONE);
    assign accept     = opt_valid && opt_ready;
    assign solved     = &known;

    // The first beat of a line is checked against the line it names on the
    // inputs; later beats and the commit use the latched line.
    always_comb begin
        sel_row    = (state == IDLE) ? row : row_q;
        ind        = int'((state == IDLE) ? line_ind : ind_q);
        len        = sel_row ? COLS : ROWS;
        line_ok    = sel_row ? (ind < ROWS) : (ind < COLS);
        line_asg   = '0;
        line_kn    = '0;
        mask       = '0;
        for (int i = 0; i < L_MAX; i++) mask[i] = (i < len);
        // An out-of-range line matches no cell, so every beat is consistent.
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (sel_row && ind == r) begin
                    line_asg[c] = assigned[r][c];
                    line_kn[c]  = known[r][c];
                end
                if (!sel_row && ind == c) begin
                    line_asg[r] = assigned[r][c];
                    line_kn[r]  = known[r][c];
                end
            end
        end
        consistent = (((option ^ line_asg) & line_kn & mask) == '0);
    end

    // Candidate grid after committing the current line.
    always_comb begin
        known_nx    = known;
        assigned_nx = assigned;
        any_new     = 1'b0;
        a_bit       = 1'b0;
        o_bit       = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((sel_row && ind == r) || (!sel_row && ind == c)) begin
                    a_bit = sel_row ? and_acc[c] : and_acc[r];
                    o_bit = sel_row ? or_acc[c]  : or_acc[r];
                    if (a_bit || !o_bit) begin
                        if (!known[r][c]) any_new = 1'b1;
                        known_nx[r][c]    = 1'b1;
                        assigned_nx[r][c] = a_bit;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = opt_last ? COMMIT : ACCUM;
            ACCUM:   if (accept && opt_last) state_nx = COMMIT;
            COMMIT:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            row_q         <= 1'b0;
            ind_q         <= '0;
            cnt           <= '0;
            and_acc       <= '1;
            or_acc        <= '0;
            known         <= '0;
            assigned      <= '0;
            surviving     <= '0;
            changed       <= 1'b0;
            contradiction <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (state == IDLE) begin
                    row_q <= row;
                    ind_q <= line_ind;
                end
                if (consistent) begin
                    if (cnt != '1) cnt <= cnt + CNT_W'(1);
                    and_acc <= and_acc & option;
                    or_acc  <= or_acc | option;
                end
            end
            if (state == COMMIT) begin
                if (line_ok && cnt != '0) begin
                    known    <= known_nx;
                    assigned <= assigned_nx;
                end
                surviving     <= line_ok ? cnt : '0;
                changed       <= line_ok && (cnt != '0) && any_new;
                contradiction <= line_ok && (cnt == '0);
            end
            // Re-arm the accumulators so the next line starts fresh in IDLE.
            if (state == DONE) begin
                cnt     <= '0;
                and_acc <= '1;
                or_acc  <= '0;
            end
        end
    end

`ifdef LINE_SOLVER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            lines_done     <= '0;
            options_pruned <= '0;
        end else begin
            if (state == DONE) lines_done <= lines_done + 32'd1;
            if (accept && !consistent) options_pruned <= options_pruned + 32'd1;
        end
    end
`endif

endmodule

// File: doc/line_solver.md
LINE_SOLVER -- requirements
Module: line_solver

Interface
REQ-001 SHALL have parameter ROWS, default 3, grid row count (>=2).
REQ-002 SHALL have parameter COLS, default 3, grid column count (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, width of the surviving-option counter.
REQ-004 SHALL define local L_MAX = max(ROWS,COLS) and IDX_W = $clog2(L_MAX), min 1.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 opt_valid  input  1  option beat valid.
REQ-008 opt_ready  output  1  block accepts a beat this cycle.
REQ-009 opt_last  input  1  beat is the final option of the current line.
REQ-010 row  input  1  1 = line is a row, 0 = line is a column; sampled on the first beat of a line.
REQ-011 line_ind  input  IDX_W  line index; sampled on the first beat of a line.
REQ-012 option  input  L_MAX  candidate fill; bit i = column i (row line) or row i (column line).
REQ-013 assigned  output  ROWS x COLS  cell values, assigned[r][c].
REQ-014 known  output  ROWS x COLS  cell-determined flags.
REQ-015 done_valid  output  1  one-cycle pulse: line result valid.
REQ-016 surviving  output  CNT_W  count of non-contradicting options for the line.
REQ-017 changed  output  1  at least one cell became known on this line.
REQ-018 contradiction  output  1  zero options survived.
REQ-019 solved  output  1  every cell of known is 1 (combinational from registers).

Function
REQ-020 States SHALL be IDLE, ACCUM, COMMIT, DONE; opt_ready = 1 only in IDLE and ACCUM.
REQ-021 A beat is accepted when opt_valid & opt_ready; the first beat in IDLE latches row and line_ind and moves to ACCUM (or COMMIT if opt_last).
REQ-022 Line length SHALL be L = COLS for rows and ROWS for columns; option bits >= L are ignored.
REQ-023 An accepted beat SHALL be consistent iff ((option ^ line_assigned) & line_known) over bits < L is zero.
REQ-024 Each consistent beat SHALL increment the survivor count (saturating at 2^CNT_W-1), AND into and_acc and OR into or_acc; accumulators initialise to all-1 / all-0 per line.
REQ-025 The beat with opt_last SHALL move to COMMIT, whether it arrives in IDLE or ACCUM.
REQ-026 In COMMIT with survivors > 0, each cell i < L SHALL become known=1 and assigned=1 if and_acc[i], known=1 and assigned=0 if ~or_acc[i]; other cells are unchanged.
REQ-027 In COMMIT with survivors = 0, the grid SHALL be unchanged and contradiction is set.
REQ-028 line_ind >= ROWS (row) or >= COLS (column) SHALL leave the grid unchanged with surviving = 0, changed = 0 and contradiction = 0; all beats are still consumed.
REQ-029 changed SHALL be 1 iff at least one cell had known 0 -> 1 in COMMIT.
REQ-030 Latency: for a last beat accepted in cycle N, the grid updates at the end of N+1 and done_valid = 1 in N+2 only; opt_ready = 0 in N+1 and N+2 and returns to 1 in N+3.
REQ-031 surviving, changed and contradiction SHALL hold their values until the next done_valid.
REQ-032 Idle cycles (opt_valid = 0) inside ACCUM SHALL not alter the accumulators.

Reset
REQ-033 With rst = 0 at a clock edge: state = IDLE, accumulators cleared, known = 0, assigned = 0, done_valid = 0, surviving = 0, changed = 0, contradiction = 0.
REQ-034 Reset during ACCUM, COMMIT or DONE SHALL discard the line with no grid update, and opt_ready = 1 in the first cycle after release.

Configuration
REQ-035 Macro LINE_SOLVER_STATS_EN defined: SHALL add outputs lines_done[31:0] (incremented per done_valid) and options_pruned[31:0] (incremented per inconsistent beat); both wrap and are reset to 0.
REQ-036 Macro LINE_SOLVER_STATS_EN undefined: these ports and counters SHALL be absent, with all other behaviour identical.

Verification (3x3)
REQ-037 Reset; row 0, one beat option=101 with opt_last -> known row0 = 111, assigned row0 = 101, surviving = 1, changed = 1, done_valid two cycles after the beat.
REQ-038 Row 1, options 110 then 011 (last) -> only cell [1][1] becomes known=1, assigned=1; surviving = 2, changed = 1.
REQ-039 After REQ-037, column 0, options 010 then 011 (last) -> 010 rejected; surviving = 1; column 0 assigned = rows{1,1,0}, all known.
REQ-040 Row 0 again after REQ-037 with options 000 and 111 -> surviving = 0, contradiction = 1, grid unchanged, changed = 0.
REQ-041 rst = 0 mid-ACCUM after 2 beats -> grid all 0 and opt_ready = 1 the cycle after release; with LINE_SOLVER_STATS_EN, counters = 0.
REQ-042 opt_valid held high across COMMIT and DONE -> no beat accepted while opt_ready = 0, and the next line starts in N+3.
